coherence_bus_rr: RTL
=====================

Name: coherence_bus_rr

Overview:
- Parametrised snooping coherence bus connecting NUM_CORES private L1 controllers to one shared L2 port.
- Successor to the fixed 4-core fixed-priority bus. Adds round-robin arbitration, multi-cycle snoop completion (per-core done), one-hot response routing, and dirty-supplier write-back to L2.
- Serialises one transaction at a time: arbitrate, broadcast snoop, collect responses, optionally access L2, respond.

Parameters:
- NUM_CORES, 4, number of L1 clients (2..16).
- LINE_ADDR_BITS, 26, line address width (ADDR_BITS - OFFSET_BITS).
- LINE_BITS, 512, cache line width in bits.
- CORE_ID_BITS, $clog2(NUM_CORES), width of the granted-core register.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- l1_req_valid  in  NUM_CORES  per-core request valid.
- l1_req_ready  out  NUM_CORES  one-hot grant/accept.
- l1_req_addr  in  NUM_CORES*LINE_ADDR_BITS  packed line addresses.
- l1_req  in  bus_req_t[NUM_CORES]  request type.
- l1_req_data  in  NUM_CORES*LINE_BITS  write-back data.
- l1_resp_valid  out  NUM_CORES  one-hot completion pulse to requester.
- l1_resp_data  out  LINE_BITS  fill data.
- l1_resp_shared  out  1  line held by another core.
- l1_snoop_valid  out  NUM_CORES  snoop broadcast; requester excluded.
- l1_snoop_addr  out  LINE_ADDR_BITS  snooped line.
- l1_snoop_req  out  bus_req_t  snooped request type.
- l1_snoop_done  in  NUM_CORES  snooper finished; its shared/dirty/data are valid this cycle.
- l1_snoop_shared  in  NUM_CORES  snooper holds line.
- l1_snoop_dirty  in  NUM_CORES  snooper held line Modified.
- l1_snoop_data  in  NUM_CORES*LINE_BITS  snooper line data.
- l2_req_valid  out  1.
- l2_req_ready  in  1.
- l2_req_addr  out  LINE_ADDR_BITS.
- l2_req_rw  out  1  0 read, 1 write.
- l2_req_data  out  LINE_BITS.
- l2_resp_valid  in  1.
- l2_resp_data  in  LINE_BITS.

Behaviour:
- Reset (sync, reset_n low at clk edge): state IDLE, rr_ptr=0, all regs 0. All outputs 0; snoop_req = BUS_RD.
- States: IDLE, SNOOP, L2_REQ, L2_WAIT, RESP.
- IDLE:
  - Grant the first valid core scanning from rr_ptr upward, wrapping.
  - Assert l1_req_ready[g] combinationally in the same cycle.
  - Latch req/addr/data/g. Set rr_ptr = (g+1) mod NUM_CORES. Go to SNOOP.
  - No valid: stay, rr_ptr unchanged.
- SNOOP:
  - l1_snoop_valid = ~onehot(g), held until every non-requester has pulsed done.
  - Each snooper's shared/dirty/data are sticky-latched in its done cycle. A snooper's done is ignored after its first pulse in the transaction.
  - Supplier: lowest-index core with latched dirty, otherwise lowest with shared.
  - On the cycle all done bits are collected:
    - BUS_UPGR goes to RESP (no data).
    - BUS_WB goes to L2_REQ (write).
    - BUS_RD/BUS_RDX with a dirty supplier: data = supplier data. RD then goes to L2_REQ (write, memory update); RDX goes to RESP.
    - RD/RDX with shared but clean supplier: data = supplier data, go to RESP.
    - RD/RDX with no holder: go to L2_REQ (read).
  - NUM_CORES-1 done pulses in one cycle complete SNOOP in that cycle.
- L2_REQ:
  - l2_req_valid held with stable addr/rw/data until l2_req_ready.
  - Write goes to RESP; read goes to L2_WAIT.
- L2_WAIT: on l2_resp_valid latch data, go to RESP.
- RESP:
  - One-cycle l1_resp_valid[g] with l1_resp_data = latched data.
  - l1_resp_shared = OR of latched shared bits, excluding the requester.
  - Return to IDLE. A new grant is possible the next cycle.
- Minimum latency: shared-hit RD is grant at T, done at T+1, resp at T+2.
- Reset mid-transaction aborts it with no response. Clients must also reset.

Optional Feature:
- Macro COHERENCE_BUS_PERF_EN.
- Defined: adds outputs perf_txn_cnt, perf_c2c_cnt, perf_l2_rd_cnt, perf_wait_cyc_cnt, each 32 bits.
  - perf_txn_cnt counts transactions; perf_c2c_cnt counts cache-to-cache transfers; perf_l2_rd_cnt counts L2 reads; perf_wait_cyc_cnt counts cycles with any unserved valid request.
  - All saturate at all-ones and reset to 0.
- Undefined: ports and logic are absent.

Decomposition:
- Shared package cache_pkg: bus_req_t {BUS_RD, BUS_RDX, BUS_UPGR, BUS_WB}, bus_state_t, LINE_BITS/ADDR defaults.
- Sub-module rr_arbiter (NUM_CORES; req, ptr in; one-hot grant, grant index out) for reuse by the L2 request queue.

Test Plan:
- Cores 0,2 both valid RD in the same cycle, rr_ptr=0 -> core 0 granted first, core 2 next; then rr_ptr=3.
- Core 1 RD 0x12, core 3 done at +3 cycles with shared=1, dirty=0, data=0xAA.. -> snoop held until done; resp_valid[1] with 0xAA.., shared=1; no L2 request.
- Core 0 RD, core 2 dirty with 0x55.. -> resp 0x55.. to core 0 and an L2 write of 0x55.. to the same address.
- Core 2 RDX, no holders, l2_req_ready delayed 4 cycles, l2 resp 0x77.. -> valid held stable; resp_valid[2] with 0x77.., shared=0.
- Core 3 WB, addr 0x40, data 0x99.. -> L2 write (rw=1) after snoop, then resp_valid[3] ack.
- reset_n low during L2_WAIT -> next cycle IDLE, all outputs 0, no response pulse.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared bus request types, FSM state constants and width defaults
package cache_pkg;

    localparam int LINE_BITS_DEF      = 512;
    localparam int LINE_ADDR_BITS_DEF = 26;

    typedef enum logic [1:0] {
        BUS_RD   = 2'd0,
        BUS_RDX  = 2'd1,
        BUS_UPGR = 2'd2,
        BUS_WB   = 2'd3
    } bus_req_t;

    typedef logic [2:0] bus_state_t;

    localparam bus_state_t ST_IDLE    = 3'd0;
    localparam bus_state_t ST_SNOOP   = 3'd1;
    localparam bus_state_t ST_L2_REQ  = 3'd2;
    localparam bus_state_t ST_L2_WAIT = 3'd3;
    localparam bus_state_t ST_RESP    = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter scanning upward from a pointer
module rr_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ID_BITS   = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [ID_BITS-1:0]   ptr,
    output logic [NUM_CORES-1:0] grant,
    output logic [ID_BITS-1:0]   grant_idx,
    output logic                 grant_valid
);

    logic [ID_BITS-1:0] idx;

    // first requester at or after ptr, wrapping past the top index
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = ID_BITS'((int'(ptr) + i) % NUM_CORES);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_rr.sv
// rtl/coherence_bus_rr.sv - round-robin snooping coherence bus to one L2 port (perf counters: COHERENCE_BUS_PERF_EN)
module coherence_bus_rr
    import cache_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int LINE_ADDR_BITS = LINE_ADDR_BITS_DEF,
    parameter int LINE_BITS      = LINE_BITS_DEF,
    parameter int CORE_ID_BITS   = $clog2(NUM_CORES)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_CORES-1:0]                l1_req_valid,
    output logic [NUM_CORES-1:0]                l1_req_ready,
    input  logic [NUM_CORES*LINE_ADDR_BITS-1:0] l1_req_addr,
    input  bus_req_t                            l1_req [NUM_CORES],
    input  logic [NUM_CORES*LINE_BITS-1:0]      l1_req_data,
    output logic [NUM_CORES-1:0]                l1_resp_valid,
    output logic [LINE_BITS-1:0]                l1_resp_data,
    output logic                                l1_resp_shared,
    output logic [NUM_CORES-1:0]                l1_snoop_valid,
    output logic [LINE_ADDR_BITS-1:0]           l1_snoop_addr,
    output bus_req_t                            l1_snoop_req,
    input  logic [NUM_CORES-1:0]                l1_snoop_done,
    input  logic [NUM_CORES-1:0]                l1_snoop_shared,
    input  logic [NUM_CORES-1:0]                l1_snoop_dirty,
    input  logic [NUM_CORES*LINE_BITS-1:0]      l1_snoop_data,
    output logic                                l2_req_valid,
    input  logic                                l2_req_ready,
    output logic [LINE_ADDR_BITS-1:0]           l2_req_addr,
    output logic                                l2_req_rw,
    output logic [LINE_BITS-1:0]                l2_req_data,
    input  logic                                l2_resp_valid,
    input  logic [LINE_BITS-1:0]                l2_resp_data
`ifdef COHERENCE_BUS_PERF_EN
    ,
    output logic [31:0]                         perf_txn_cnt,
    output logic [31:0]                         perf_c2c_cnt,
    output logic [31:0]                         perf_l2_rd_cnt,
    output logic [31:0]                         perf_wait_cyc_cnt
`endif
);

    bus_state_t                state;
    logic [CORE_ID_BITS-1:0]   rr_ptr;
    logic [CORE_ID_BITS-1:0]   gnt_q;
    bus_req_t                  req_q;
    logic [LINE_ADDR_BITS-1:0] addr_q;
    logic [LINE_BITS-1:0]      line_q;
    logic                      l2_rw_q;
    logic [NUM_CORES-1:0]      done_q;
    logic [NUM_CORES-1:0]      shared_q;
    logic                      sup_vld_q;
    logic                      sup_dirty_q;
    logic [CORE_ID_BITS-1:0]   sup_idx_q;

    logic [NUM_CORES-1:0]      arb_grant;
    logic [CORE_ID_BITS-1:0]   arb_idx;
    logic                      arb_valid;

    logic [NUM_CORES-1:0]      gnt_oh;
    logic [NUM_CORES-1:0]      new_done;
    logic [NUM_CORES-1:0]      done_nxt;
    logic [NUM_CORES-1:0]      shared_nxt;
    logic                      all_done;
    logic                      sup_vld_n;
    logic                      sup_dirty_n;
    logic [CORE_ID_BITS-1:0]   sup_idx_n;
    logic [LINE_BITS-1:0]      sup_data_n;

    rr_arbiter #(
        .NUM_CORES (NUM_CORES),
        .ID_BITS   (CORE_ID_BITS)
    ) u_arb (
        .req         (l1_req_valid),
        .ptr         (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign gnt_oh     = NUM_CORES'(1) << gnt_q;
    assign new_done   = (state == ST_SNOOP) ? (l1_snoop_done & ~done_q & ~gnt_oh) : '0;
    assign done_nxt   = done_q | new_done;
    assign shared_nxt = shared_q | (new_done & l1_snoop_shared);
    assign all_done   = &(done_nxt | gnt_oh);

    // fold this cycle's first-time responders into the best supplier so far;
    // dirty beats clean, lower index wins among equals. line_q holds the
    // current best supplier's data while an RD/RDX is snooping.
    always_comb begin
        sup_vld_n   = sup_vld_q;
        sup_dirty_n = sup_dirty_q;
        sup_idx_n   = sup_idx_q;
        sup_data_n  = line_q;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (new_done[j] && (l1_snoop_dirty[j] || l1_snoop_shared[j])) begin
                if (!sup_vld_n || (l1_snoop_dirty[j] && !sup_dirty_n) ||
                    ((l1_snoop_dirty[j] == sup_dirty_n) && (CORE_ID_BITS'(j) < sup_idx_n))) begin
                    sup_vld_n   = 1'b1;
                    sup_dirty_n = l1_snoop_dirty[j];
                    sup_idx_n   = CORE_ID_BITS'(j);
                    sup_data_n  = l1_snoop_data[j*LINE_BITS +: LINE_BITS];
                end
            end
        end
    end

    // transaction sequencer: grant, snoop, optional L2 access, respond
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            gnt_q       <= '0;
            req_q       <= BUS_RD;
            addr_q      <= '0;
            line_q      <= '0;
            l2_rw_q     <= 1'b0;
            done_q      <= '0;
            shared_q    <= '0;
            sup_vld_q   <= 1'b0;
            sup_dirty_q <= 1'b0;
            sup_idx_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt_q       <= arb_idx;
                        req_q       <= l1_req[arb_idx];
                        addr_q      <= l1_req_addr[arb_idx*LINE_ADDR_BITS +: LINE_ADDR_BITS];
                        line_q      <= l1_req_data[arb_idx*LINE_BITS +: LINE_BITS];
                        rr_ptr      <= CORE_ID_BITS'((int'(arb_idx) + 1) % NUM_CORES);
                        done_q      <= '0;
                        shared_q    <= '0;
                        sup_vld_q   <= 1'b0;
                        sup_dirty_q <= 1'b0;
                        sup_idx_q   <= '0;
                        state       <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    done_q      <= done_nxt;
                    shared_q    <= shared_nxt;
                    sup_vld_q   <= sup_vld_n;
                    sup_dirty_q <= sup_dirty_n;
                    sup_idx_q   <= sup_idx_n;
                    if (req_q == BUS_RD || req_q == BUS_RDX)
                        line_q <= sup_data_n;
                    if (all_done) begin
                        case (req_q)
                            BUS_UPGR: begin
                                line_q <= '0;
                                state  <= ST_RESP;
                            end
                            BUS_WB: begin
                                l2_rw_q <= 1'b1;
                                state   <= ST_L2_REQ;
                            end
                            default: begin
                                if (!sup_vld_n) begin
                                    l2_rw_q <= 1'b0;
                                    state   <= ST_L2_REQ;
                                end else if (sup_dirty_n && req_q == BUS_RD) begin
                                    l2_rw_q <= 1'b1;
                                    state   <= ST_L2_REQ;
                                end else begin
                                    state <= ST_RESP;
                                end
                            end
                        endcase
                    end
                end
                ST_L2_REQ: begin
                    if (l2_req_ready)
                        state <= l2_rw_q ? ST_RESP : ST_L2_WAIT;
                end
                ST_L2_WAIT: begin
                    if (l2_resp_valid) begin
                        line_q <= l2_resp_data;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign l1_req_ready   = (state == ST_IDLE)   ? arb_grant : '0;
    assign l1_snoop_valid = (state == ST_SNOOP)  ? ~gnt_oh   : '0;
    assign l1_snoop_addr  = (state == ST_SNOOP)  ? addr_q    : '0;
    assign l1_snoop_req   = (state == ST_SNOOP)  ? req_q     : BUS_RD;
    assign l1_resp_valid  = (state == ST_RESP)   ? gnt_oh    : '0;
    assign l1_resp_data   = (state == ST_RESP)   ? line_q    : '0;
    assign l1_resp_shared = (state == ST_RESP) && |(shared_q & ~gnt_oh);
    assign l2_req_valid   = (state == ST_L2_REQ);
    assign l2_req_addr    = (state == ST_L2_REQ) ? addr_q    : '0;
    assign l2_req_rw      = (state == ST_L2_REQ) && l2_rw_q;
    assign l2_req_data    = (state == ST_L2_REQ) ? line_q    : '0;

`ifdef COHERENCE_BUS_PERF_EN
    // saturating event counters
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_txn_cnt      <= '0;
            perf_c2c_cnt      <= '0;
            perf_l2_rd_cnt    <= '0;
            perf_wait_cyc_cnt <= '0;
        end else begin
            if (state == ST_RESP && perf_txn_cnt != '1)
                perf_txn_cnt <= perf_txn_cnt + 32'd1;
            if (state == ST_SNOOP && all_done && sup_vld_n &&
                (req_q == BUS_RD || req_q == BUS_RDX) && perf_c2c_cnt != '1)
                perf_c2c_cnt <= perf_c2c_cnt + 32'd1;
            if (state == ST_L2_REQ && l2_req_ready && !l2_rw_q && perf_l2_rd_cnt != '1)
                perf_l2_rd_cnt <= perf_l2_rd_cnt + 32'd1;
            if (|(l1_req_valid & ~l1_req_ready) && perf_wait_cyc_cnt != '1)
                perf_wait_cyc_cnt <= perf_wait_cyc_cnt + 32'd1;
        end
    end
`endif

endmodule
